uart_fifo: RTL
==============

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 The block SHALL have these parameters: DATA_BITS, default 8, frame data width (5..9); FIFO_DEPTH, default 4, entries per TX and RX FIFO (power of 2, >=2); BRG_WIDTH, default 16, baud divisor width.
REQ-002 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
 clk  in  1  clock
 rst  in  1  sync active-high reset
 UART_TXD  out  1  serial out, registered, idle high
 UART_RXD  in  1  serial in, asynchronous
 tx_en  in  1  transmitter enable
 rx_en  in  1  receiver enable
 brg_div  in  BRG_WIDTH  bit period = 16*(brg_div+1) clk cycles
 parity_odd  in  1  parity sense (1 = odd), used only under REQ-021
 tx_wr_en  in  1  push tx_data into TX FIFO
 tx_data  in  DATA_BITS  transmit word
 tx_full / tx_empty  out  1  TX FIFO status
 tx_busy  out  1  frame in progress
 rx_rd_en  in  1  pop RX FIFO head
 rx_data  out  DATA_BITS  RX FIFO head (show-ahead)
 rx_valid  out  1  RX FIFO non-empty
 rx_overrun / rx_frame_err / rx_parity_err  out  1  sticky error flags
 rx_err_clr  in  1  clear all sticky error flags
 txif  out  1  equals !tx_full
 rxif  out  1  equals rx_valid

Function
REQ-004 Frame format SHALL be: start bit (0), DATA_BITS data bits LSB first, optional parity bit (REQ-021), one stop bit (1); each bit SHALL last exactly P = 16*(brg_div+1) cycles.
REQ-005 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START when tx_en=1 and the TX FIFO is non-empty, popping the head in that cycle; UART_TXD SHALL go low on the following cycle.
REQ-006 STOP->START SHALL occur directly (back-to-back frames, no idle gap) if tx_en=1 and the FIFO is non-empty at the end of the stop bit; otherwise STOP->IDLE.
REQ-007 Deasserting tx_en mid-frame SHALL complete the current frame and start no new one.
REQ-008 tx_busy SHALL be 1 in every TX state except IDLE.
REQ-009 tx_wr_en while tx_full=1 SHALL be ignored; push and pop in the same cycle on a full TX FIFO SHALL both take effect.
REQ-010 UART_RXD SHALL pass through a 2-flop synchroniser; the RX FSM (IDLE, START, DATA, PARITY, STOP) SHALL leave IDLE on a synchronised falling edge while rx_en=1.
REQ-011 In START the line SHALL be resampled at P/2; if high, it is a false start and the FSM SHALL return to IDLE with nothing stored.
REQ-012 Data, parity and stop bits SHALL each be sampled once, P cycles after the previous sample point.
REQ-013 Stop bit sampled 0 SHALL set rx_frame_err; the word SHALL still be stored; the FSM SHALL return to IDLE and wait for the line to go high before detecting a new start.
REQ-014 A completed word arriving with the RX FIFO full SHALL be dropped and set rx_overrun; with rx_rd_en asserted in the same cycle, the pop SHALL occur first and the word SHALL be stored with no overrun.
REQ-015 rx_rd_en while rx_valid=0 SHALL be ignored; rx_data is undefined when empty.
REQ-016 rx_en=0 SHALL abort the receiver to IDLE immediately; FIFO contents are kept.
REQ-017 rx_err_clr SHALL clear the flags next cycle; a simultaneous error set SHALL win.
REQ-018 brg_div changes SHALL take effect only from the next frame start.

Reset
REQ-019 rst SHALL force: both FSMs to IDLE, both FIFOs empty, UART_TXD=1, tx_empty=1, tx_full=0, tx_busy=0, rx_valid=0, all error flags 0, txif=1, rxif=0, all counters 0.
REQ-020 rst asserted mid-frame SHALL abort the frame, with UART_TXD=1 on the cycle after rst is sampled.

Configuration
REQ-021 Macro UART_FIFO_PARITY_EN: when defined, a parity bit SHALL follow the data bits (even if parity_odd=0, odd if parity_odd=1); an RX mismatch SHALL set rx_parity_err and the word SHALL still be stored. When undefined, PARITY states SHALL be absent, parity_odd SHALL be ignored and rx_parity_err SHALL be tied 0.

Verification
REQ-022 brg_div=0, tx_en=1, write 0xA5 -> UART_TXD low 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high; tx_busy high for 160 cycles.
REQ-023 TXD looped to RXD, rx_en=1, send 0x3C -> rx_valid=1, rx_data=0x3C; rx_rd_en -> rx_valid=0.
REQ-024 With tx_en=0, 5 writes -> tx_full=1 after 4 and the 5th is dropped; then tx_en=1 -> 4 contiguous frames with no idle gap.
REQ-025 5 frames received with no read -> rx_overrun=1, first 4 words kept in order; rx_err_clr -> rx_overrun=0.
REQ-026 RXD low 4 cycles (brg_div=0) -> nothing stored; stop bit driven 0 -> rx_frame_err=1; with the macro defined, parity_odd=1, 0x01 sent with a parity bit of 1 -> rx_parity_err=1.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: full-duplex UART with show-ahead TX and RX FIFOs.
// Frame: start(0), DATA_BITS data LSB first, optional parity, stop(1); bit = 16*(brg_div+1) clk.
// Optional feature macro: UART_FIFO_PARITY_EN adds a parity bit (parity_odd selects odd sense).
module uart_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BRG_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 UART_TXD,
    input  logic                 UART_RXD,
    input  logic                 tx_en,
    input  logic                 rx_en,
    input  logic [BRG_WIDTH-1:0] brg_div,
    input  logic                 parity_odd,
    input  logic                 tx_wr_en,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 tx_busy,
    input  logic                 rx_rd_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    input  logic                 rx_err_clr,
    output logic                 txif,
    output logic                 rxif
);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = BRG_WIDTH + 4;
    localparam logic [CNTW-1:0] FullCnt = CNTW'(FIFO_DEPTH);
    localparam logic [3:0]      LastBit = 4'(DATA_BITS - 1);

`ifdef UART_FIFO_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wp_q, tx_rp_q;
    logic [CNTW-1:0]      tx_cnt_q;
    logic                 tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_full  = (tx_cnt_q == FullCnt);
    assign tx_empty = (tx_cnt_q == '0);
    assign txif     = !tx_full;
    assign tx_head  = tx_mem[tx_rp_q];
    // A push on a full FIFO is accepted only when the same cycle pops the head.
    assign tx_push  = tx_wr_en && (!tx_full || tx_pop);

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CNTW'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CNTW'(1);
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= tx_data;
    end

    // ---------------- TX FSM ----------------
    state_e               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_tmr_q, tx_tmr_d, tx_lim_q, tx_lim_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic                 txd_q, txd_d;
    logic                 tx_end, tx_start, tx_load;
`ifdef UART_FIFO_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_end   = (tx_tmr_q == tx_lim_q);
    assign tx_start = tx_en && !tx_empty;
    assign tx_busy  = (tx_state_q != StIdle);
    assign UART_TXD = txd_q;

    // TX next state; the bit period is latched at each frame start
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tmr_d   = tx_tmr_q + CW'(1);
        tx_lim_d   = tx_lim_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
`ifdef UART_FIFO_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        unique case (tx_state_q)
            StIdle: begin
                tx_tmr_d = '0;
                txd_d    = 1'b1;
                tx_load  = tx_start;
            end
            StStart: if (tx_end) begin
                tx_tmr_d   = '0;
                tx_state_d = StData;
                tx_bit_d   = '0;
                txd_d      = tx_shift_q[0];
            end
            StData: if (tx_end) begin
                tx_tmr_d = '0;
                if (tx_bit_q == LastBit) begin
`ifdef UART_FIFO_PARITY_EN
                    tx_state_d = StParity;
                    txd_d      = tx_par_q;
`else
                    tx_state_d = StStop;
                    txd_d      = 1'b1;
`endif
                end else begin
                    tx_shift_d = tx_shift_q >> 1;
                    txd_d      = tx_shift_d[0];
                    tx_bit_d   = tx_bit_q + 4'd1;
                end
            end
`ifdef UART_FIFO_PARITY_EN
            StParity: if (tx_end) begin
                tx_tmr_d   = '0;
                tx_state_d = StStop;
                txd_d      = 1'b1;
            end
`endif
            StStop: if (tx_end) begin
                tx_tmr_d   = '0;
                tx_state_d = StIdle;
                txd_d      = 1'b1;
                tx_load    = tx_start;
            end
            default: tx_state_d = StIdle;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = StStart;
            tx_tmr_d   = '0;
            tx_lim_d   = {brg_div, 4'hF};
            tx_shift_d = tx_head;
            txd_d      = 1'b0;
`ifdef UART_FIFO_PARITY_EN
            tx_par_d   = (^tx_head) ^ parity_odd;
`endif
        end
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= StIdle;
            tx_tmr_q   <= '0;
            tx_lim_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
`ifdef UART_FIFO_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_lim_q   <= tx_lim_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
`ifdef UART_FIFO_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // ---------------- RX FSM ----------------
    state_e               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_tmr_q, rx_tmr_d, rx_lim_q, rx_lim_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic                 rx_end, rx_half, rx_fall;
    logic                 rx_push_req, frame_set, parity_set, overrun_set;

    assign rx_end  = (rx_tmr_q == rx_lim_q);
    assign rx_half = (rx_tmr_q == (rx_lim_q >> 1));
    // Edge detection needs a high sample first, so a stuck-low line never retriggers.
    assign rx_fall = rxd_prev_q && !rxd_sync_q;

    // RX next state; samples are taken mid-bit, P cycles apart
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tmr_d    = rx_tmr_q + CW'(1);
        rx_lim_d    = rx_lim_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rx_push_req = 1'b0;
        frame_set   = 1'b0;
        parity_set  = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                rx_tmr_d = '0;
                if (rx_fall) begin
                    rx_state_d = StStart;
                    rx_lim_d   = {brg_div, 4'hF};
                end
            end
            StStart: if (rx_half) begin
                rx_tmr_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rxd_sync_q ? StIdle : StData;
            end
            StData: if (rx_end) begin
                rx_tmr_d   = '0;
                rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
                if (rx_bit_q == LastBit) begin
`ifdef UART_FIFO_PARITY_EN
                    rx_state_d = StParity;
`else
                    rx_state_d = StStop;
`endif
                end
            end
`ifdef UART_FIFO_PARITY_EN
            StParity: if (rx_end) begin
                rx_tmr_d   = '0;
                parity_set = (rxd_sync_q != ((^rx_shift_q) ^ parity_odd));
                rx_state_d = StStop;
            end
`endif
            StStop: if (rx_end) begin
                rx_tmr_d    = '0;
                rx_push_req = 1'b1;
                frame_set   = !rxd_sync_q;
                rx_state_d  = StIdle;
            end
            default: rx_state_d = StIdle;
        endcase
        if (!rx_en) begin
            rx_state_d  = StIdle;
            rx_tmr_d    = '0;
            rx_push_req = 1'b0;
            frame_set   = 1'b0;
            parity_set  = 1'b0;
        end
    end

    // RX state register and input synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= StIdle;
            rx_tmr_q   <= '0;
            rx_lim_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tmr_q   <= rx_tmr_d;
            rx_lim_q   <= rx_lim_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rxd_meta_q <= UART_RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wp_q, rx_rp_q;
    logic [CNTW-1:0]      rx_cnt_q;
    logic                 rx_full, rx_push, rx_pop;

    assign rx_full     = (rx_cnt_q == FullCnt);
    assign rx_valid    = (rx_cnt_q != '0);
    assign rxif        = rx_valid;
    assign rx_data     = rx_mem[rx_rp_q];
    assign rx_pop      = rx_rd_en && rx_valid;
    // A same-cycle pop frees the slot, so the new word is kept.
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign overrun_set = rx_push_req && rx_full && !rx_pop;

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CNTW'(1);
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CNTW'(1);
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_shift_d;
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    logic overrun_q, frame_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            overrun_q <= (overrun_q && !rx_err_clr) || overrun_set;
            frame_q   <= (frame_q && !rx_err_clr) || frame_set;
        end
    end
    assign rx_overrun   = overrun_q;
    assign rx_frame_err = frame_q;

`ifdef UART_FIFO_PARITY_EN
    logic parity_q;
    // Sticky parity error flag
    always_ff @(posedge clk) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= (parity_q && !rx_err_clr) || parity_set;
    end
    assign rx_parity_err = parity_q;
`else
    logic unused_parity_set;
    assign unused_parity_set = parity_set;
    assign rx_parity_err     = 1'b0;
`endif

endmodule
